sequence_player: RTL and testbench

//  Plays the stored Simon colour sequence back to the player on the LEDs, one colour per timer step.

---
 rtl/simon_pkg.sv | 23 ++
 rtl/sequence_player.sv | 109 ++++++++++
 tb/tb_sequence_player.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared Simon game types: colour codes, playback FSM states, LED decode.
package simon_pkg;

   localparam int MAX_ROUNDS = 32;

   typedef logic [1:0] colour_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SYNC = 3'd1,
      ON   = 3'd2,
      GAP  = 3'd3,
      FIN  = 3'd4
   } play_state_t;

   function automatic logic [3:0] colour_onehot(input colour_t c);
      logic [3:0] oh;
      oh = '0;
      oh[c] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/sequence_player.sv
// Plays the stored colour sequence on the LEDs, one phase per timer pulse.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; LEDs dark
// SYNC  | LEDs dark, waiting for the first pulse so ON is a full period
// ON    | showing colour_q on the LEDs
// GAP   | LEDs dark between colours; decides next colour or finish
// FIN   | one-cycle done pulse, returns to IDLE
module sequence_player #(
   parameter int MAX_ROUNDS = simon_pkg::MAX_ROUNDS,
   parameter int IDX_W      = 6,
   parameter int N_LEDS     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [IDX_W-1:0]  round_len,
   input  logic              pulse,
   input  logic [1:0]        colour_i,
   output logic [IDX_W-1:0]  colour_idx,
   output logic [N_LEDS-1:0] led_o,
   output logic              busy,
   output logic              done
);
   import simon_pkg::*;

   play_state_t       state, state_n;
   logic [IDX_W-1:0]  idx_n;
   logic [IDX_W-1:0]  len_q, len_n;
   colour_t           colour_q, colour_n;
   logic [N_LEDS-1:0] led_n;
   logic [IDX_W-1:0]  len_clamped;

   // Clamp the requested length to the longest playable sequence.
   always_comb begin
      len_clamped = round_len;
      if (round_len > IDX_W'(MAX_ROUNDS))
         len_clamped = IDX_W'(MAX_ROUNDS);
   end

   // Next-state, datapath updates and decoded outputs for the next state.
   always_comb begin
      state_n  = state;
      idx_n    = colour_idx;
      len_n    = len_q;
      colour_n = colour_q;
      unique case (state)
         IDLE: begin
            if (start) begin
               len_n   = len_clamped;
               idx_n   = '0;
               state_n = (len_clamped == '0) ? FIN : SYNC;
            end
         end
         SYNC: begin
            if (pulse) begin
               colour_n = colour_i;
               state_n  = ON;
            end
         end
         ON: begin
            if (pulse) begin
               idx_n   = colour_idx + IDX_W'(1);
               state_n = GAP;
            end
         end
         GAP: begin
            if (pulse) begin
               if (colour_idx == len_q) begin
                  state_n = FIN;
               end else begin
                  colour_n = colour_i;
                  state_n  = ON;
               end
            end
         end
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase

      // Codes at or above N_LEDS decode to all-dark.
      led_n = '0;
      for (int i = 0; i < N_LEDS; i++)
         led_n[i] = (state_n == ON) && (int'(colour_n) == i);
   end

   // State, datapath and registered output decodes; reset wins over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         colour_idx <= '0;
         len_q      <= '0;
         colour_q   <= '0;
         led_o      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         colour_idx <= idx_n;
         len_q      <= len_n;
         colour_q   <= colour_n;
         led_o      <= led_n;
         busy       <= (state_n == SYNC) || (state_n == ON) || (state_n == GAP);
         done       <= (state_n == FIN);
      end
   end

endmodule

// File: tb/tb_sequence_player.sv
// Scoreboard bench for sequence_player: stimulus queues expected LED changes
// and done pulses; a negedge monitor pops and compares as the DUT shows them.
module tb_sequence_player;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [5:0] round_len = '0;
   logic       pulse = 1'b0;
   logic [1:0] colour_i;
   logic [5:0] colour_idx;
   logic [3:0] led_o;
   logic       busy;
   logic       done;

   logic [1:0] store [64];
   assign colour_i = store[colour_idx];

   sequence_player dut (
      .clk(clk), .reset(reset), .start(start), .round_len(round_len),
      .pulse(pulse), .colour_i(colour_i), .colour_idx(colour_idx),
      .led_o(led_o), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic is_done; logic [7:0] val; } ev_t;
   ev_t exp_q [$];

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   logic [3:0] last_led = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic sb_pop(input logic is_done, input logic [7:0] val);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL sb_unexpected kind=%0d actual=%0h expected=none", is_done, val);
      end else begin
         e = exp_q.pop_front();
         if (e.is_done !== is_done || e.val !== val) begin
            errors++;
            $display("FAIL sb_event actual kind=%0d val=%0h expected kind=%0d val=%0h",
                     is_done, val, e.is_done, e.val);
         end
      end
   endtask

   // Monitor: done pulses carry colour_idx, LED changes carry the new pattern.
   always @(negedge clk) begin
      if (mon_en) begin
         if (done === 1'b1) sb_pop(1'b1, {2'b0, colour_idx});
         if (led_o !== last_led) sb_pop(1'b0, {4'b0, led_o});
      end
      last_led = led_o;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_led(input logic [3:0] v);
      exp_q.push_back('{is_done: 1'b0, val: {4'b0, v}});
   endtask

   task automatic push_done(input logic [5:0] idx);
      exp_q.push_back('{is_done: 1'b1, val: {2'b0, idx}});
   endtask

   task automatic do_start(input logic [5:0] len);
      round_len = len;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic do_pulse();
      pulse = 1'b1;
      cyc(1);
      pulse = 1'b0;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 64; i++) store[i] = 2'd0;

      cyc(2);
      reset = 1'b0;
      chk("reset_led", {28'b0, led_o}, 32'h0);
      chk("reset_busy", {31'b0, busy}, 32'h0);
      chk("reset_done", {31'b0, done}, 32'h0);
      chk("reset_idx", {26'b0, colour_idx}, 32'h0);
      mon_en = 1'b1;

      // Test 1: length 3, colours {2,0,3}, pulses 10 cycles apart.
      store[0] = 2'd2; store[1] = 2'd0; store[2] = 2'd3;
      push_led(4'b0100); push_led(4'b0000); push_led(4'b0001);
      push_led(4'b0000); push_led(4'b1000); push_led(4'b0000);
      push_done(6'd3);
      do_start(6'd3);
      chk("t1_busy_after_start", {31'b0, busy}, 32'h1);
      chk("t1_sync_dark", {28'b0, led_o}, 32'h0);
      for (int p = 1; p <= 7; p++) begin
         do_pulse();
         if (p == 7) begin
            chk("t1_done_after_p7", {31'b0, done}, 32'h1);
            chk("t1_busy_low_at_done", {31'b0, busy}, 32'h0);
         end else begin
            chk("t1_busy_mid", {31'b0, busy}, 32'h1);
         end
         cyc(9);
      end

      // Test 2: zero length goes straight to FIN.
      push_done(6'd0);
      do_start(6'd0);
      chk("t2_done", {31'b0, done}, 32'h1);
      chk("t2_busy", {31'b0, busy}, 32'h0);
      chk("t2_idx", {26'b0, colour_idx}, 32'h0);
      cyc(1);
      chk("t2_done_one_cycle", {31'b0, done}, 32'h0);
      cyc(3);

      // Test 3: starts during playback are ignored.
      store[0] = 2'd1; store[1] = 2'd3; store[2] = 2'd2;
      push_led(4'b0010); push_led(4'b0000); push_led(4'b1000);
      push_led(4'b0000); push_led(4'b0100); push_led(4'b0000);
      push_done(6'd3);
      do_start(6'd3);
      for (int p = 1; p <= 7; p++) begin
         do_pulse();
         cyc(2);
         if (p == 3) do_start(6'd5);
         if (p == 4) do_start(6'd3);
      end
      cyc(3);

      // Test 4: reset during ON of colour 1, then a clean replay from colour 0.
      store[0] = 2'd1; store[1] = 2'd2;
      push_led(4'b0010); push_led(4'b0000); push_led(4'b0100); push_led(4'b0000);
      do_start(6'd2);
      for (int p = 1; p <= 3; p++) begin
         do_pulse();
         cyc(2);
      end
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      chk("t4_led", {28'b0, led_o}, 32'h0);
      chk("t4_busy", {31'b0, busy}, 32'h0);
      chk("t4_idx", {26'b0, colour_idx}, 32'h0);
      chk("t4_done", {31'b0, done}, 32'h0);
      cyc(3);
      push_led(4'b0010); push_led(4'b0000); push_led(4'b0100); push_led(4'b0000);
      push_done(6'd2);
      do_start(6'd2);
      for (int p = 1; p <= 5; p++) begin
         do_pulse();
         cyc(2);
      end

      // Test 5: length 40 clamps to 32 colours, 65 pulses.
      for (int i = 0; i < 32; i++) begin
         store[i] = 2'(i * 3);
         push_led(4'b0001 << store[i]);
         push_led(4'b0000);
      end
      push_done(6'd32);
      do_start(6'd40);
      for (int p = 1; p <= 65; p++) begin
         do_pulse();
         if (p >= 64) chk("t5_done_at_p65", {31'b0, done}, (p == 65) ? 32'h1 : 32'h0);
         cyc(1);
      end
      cyc(3);

      // Test 6: pulse held high through a length-2 playback.
      store[0] = 2'd3; store[1] = 2'd1;
      push_led(4'b1000); push_led(4'b0000); push_led(4'b0010); push_led(4'b0000);
      push_done(6'd2);
      pulse = 1'b1;
      do_start(6'd2);
      // Count edges after the accepting edge: SYNC->ON->GAP->ON->GAP->FIN is 5.
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         cyc(1);
         n++;
      end
      pulse = 1'b0;
      chk("t6_edges_to_done", n, 32'd5);
      cyc(4);

      chk("sb_queue_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
